// File: rtl/bin_to_bcd_seq.sv
// Sequential 14-bit binary to 4-digit packed BCD converter.
// Uses iterative double-dabble, one bit per clock, with optional saturation above 9999.
module bin_to_bcd_seq #(
    parameter int SATURATE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [13:0] bin_in,
    output logic [15:0] bcd_out,
    output logic        busy,
    output logic        done,
    output logic        overflow
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [19:0] scratch_q, scratch_d;
    logic [19:0] scratch_adj_s;
    logic [13:0] shreg_q, shreg_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ovf_pend_q, ovf_pend_d;
    logic [15:0] bcd_q, bcd_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        overflow_q, overflow_d;

    function automatic logic [3:0] add3(input logic [3:0] digit);
        if (digit >= 4'd5) begin
            return digit + 4'd3;
        end else begin
            return digit;
        end
    endfunction

    // Pre-shift correction of every scratch digit
    always_comb begin
        scratch_adj_s = scratch_q;
        for (int i = 0; i < 5; i++) begin
            scratch_adj_s[4*i +: 4] = add3(scratch_q[4*i +: 4]);
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        scratch_d  = scratch_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shreg_d    = bin_in;
                    scratch_d  = 20'd0;
                    cnt_d      = 4'd0;
                    ovf_pend_d = (bin_in > 14'd9999);
                    busy_d     = 1'b1;
                    state_d    = S_CONV;
                end else begin
                    state_d    = S_IDLE;
                end
            end
            S_CONV: begin
                scratch_d = (scratch_adj_s << 1) | {19'd0, shreg_q[13]};
                shreg_d   = shreg_q << 1;
                cnt_d     = cnt_q + 4'd1;
                if (cnt_q == 4'd13) begin
                    state_d    = S_DONE;
                    done_d     = 1'b1;
                    overflow_d = ovf_pend_q;
                    // Ten-thousands digit is dropped; saturation replaces it entirely
                    if ((SATURATE != 0) && ovf_pend_q) begin
                        bcd_d = 16'h9999;
                    end else begin
                        bcd_d = scratch_d[15:0];
                    end
                end else begin
                    busy_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            scratch_q  <= 20'd0;
            shreg_q    <= 14'd0;
            cnt_q      <= 4'd0;
            ovf_pend_q <= 1'b0;
            bcd_q      <= 16'h0000;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            scratch_q  <= scratch_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            bcd_q      <= bcd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

    assign bcd_out  = bcd_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: a saturating and a wrapping instance share stimulus,
// and expected results are queued at each start and compared on every done pulse.
module tb_bin_to_bcd_seq;

    typedef struct {
        logic [15:0] bs;
        logic [15:0] bw;
        logic        ov;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [13:0] bin_in = 14'd0;
    logic [15:0] bcd_s, bcd_w;
    logic        busy_s, busy_w, done_s, done_w, ovf_s, ovf_w;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   done_cyc[$];
    exp_t sb[$];
    exp_t mon_e;

    bin_to_bcd_seq #(.SATURATE(1)) dut_s (
        .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
        .bcd_out(bcd_s), .busy(busy_s), .done(done_s), .overflow(ovf_s)
    );

    bin_to_bcd_seq #(.SATURATE(0)) dut_w (
        .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
        .bcd_out(bcd_w), .busy(busy_w), .done(done_w), .overflow(ovf_w)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] to_bcd(input int v);
        int w;
        w = v % 10000;
        return {4'(w / 1000), 4'((w / 100) % 10), 4'((w / 10) % 10), 4'(w % 10)};
    endfunction

    // Scoreboard: every done pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (done_s) begin
            done_cnt++;
            done_cyc.push_back(cyc);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done bcd=%h ovf=%b required no done", bcd_s, ovf_s);
            end else begin
                mon_e = sb.pop_front();
                if ({bcd_s, ovf_s, bcd_w, ovf_w, done_w} !== {mon_e.bs, mon_e.ov, mon_e.bw, mon_e.ov, 1'b1}) begin
                    errors++;
                    $display("FAIL result sat=%h/%b wrap=%h/%b done_w=%b required sat=%h/%b wrap=%h/%b done_w=1",
                             bcd_s, ovf_s, bcd_w, ovf_w, done_w, mon_e.bs, mon_e.ov, mon_e.bw, mon_e.ov);
                end
            end
        end
    end

    task automatic push_exp(input int v);
        exp_t e;
        e.bw = to_bcd(v);
        e.bs = (v > 9999) ? 16'h9999 : to_bcd(v);
        e.ov = (v > 9999);
        sb.push_back(e);
    endtask

    // Returns at the negedge following the accepting edge E0
    task automatic pulse_start(input int v);
        @(negedge clk);
        bin_in = 14'(v);
        start  = 1'b1;
        push_exp(v);
        @(negedge clk);
        start  = 1'b0;
    endtask

    // lat counts negedges from the current one (1) to the one showing done
    task automatic wait_done(input logic [15:0] hold_val, output int lat, output int busy_n, output int hold_bad);
        lat = -1;
        busy_n = 0;
        hold_bad = 0;
        for (int k = 1; k <= 40; k++) begin
            if (done_s) begin
                lat = k;
                break;
            end
            if (busy_s) busy_n++;
            if (bcd_s !== hold_val) hold_bad++;
            if (busy_w !== busy_s) hold_bad++;
            @(negedge clk);
        end
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout no done within 40 cycles required done");
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({bcd_s, busy_s, done_s, ovf_s} !== {16'h0000, 3'b000}) begin
            errors++;
            $display("FAIL reset_state bcd=%h busy=%b done=%b ovf=%b required 0000/0/0/0", bcd_s, busy_s, done_s, ovf_s);
        end
        bin_in = 14'd100;
        start  = 1'b1;
        @(negedge clk);
        checks++;
        if (busy_s !== 1'b0) begin
            errors++;
            $display("FAIL rst_over_start busy=%b required 0", busy_s);
        end
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy_s, done_s} !== 2'b00) begin
            errors++;
            $display("FAIL post_reset_idle busy=%b done=%b required 0/0", busy_s, done_s);
        end
    endtask

    task automatic test_basic();
        int lat, busy_n, hold_bad;
        pulse_start(1234);
        wait_done(16'h0000, lat, busy_n, hold_bad);
        checks++;
        if (lat !== 15 || busy_n !== 14 || hold_bad !== 0 || busy_s !== 1'b0) begin
            errors++;
            $display("FAIL basic_timing lat=%0d busy_cycles=%0d hold_bad=%0d busy_at_done=%b required 15/14/0/0",
                     lat, busy_n, hold_bad, busy_s);
        end
        @(negedge clk);
        checks++;
        if (done_s !== 1'b0 || bcd_s !== 16'h1234) begin
            errors++;
            $display("FAIL basic_done_width done=%b bcd=%h required 0/1234", done_s, bcd_s);
        end
    endtask

    task automatic test_zero_max();
        int lat, busy_n, hold_bad;
        pulse_start(0);
        wait_done(16'h1234, lat, busy_n, hold_bad);
        pulse_start(9999);
        wait_done(16'h0000, lat, busy_n, hold_bad);
        checks++;
        if (lat !== 15 || hold_bad !== 0) begin
            errors++;
            $display("FAIL zero_hold lat=%0d hold_bad=%0d required 15/0", lat, hold_bad);
        end
    endtask

    task automatic test_overflow();
        int lat, busy_n, hold_bad;
        pulse_start(12345);
        wait_done(16'h9999, lat, busy_n, hold_bad);
        pulse_start(16383);
        wait_done(16'h9999, lat, busy_n, hold_bad);
        checks++;
        if (lat !== 15 || busy_n !== 14) begin
            errors++;
            $display("FAIL overflow_timing lat=%0d busy_cycles=%0d required 15/14", lat, busy_n);
        end
    endtask

    task automatic test_ignore_start();
        int lat, busy_n, hold_bad, n0, extra;
        pulse_start(42);
        n0 = done_cnt;
        repeat (4) @(negedge clk);
        bin_in = 14'd77;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        bin_in = 14'd9000;
        wait_done(16'h9999, lat, busy_n, hold_bad);
        checks++;
        if (lat !== 10 || hold_bad !== 0) begin
            errors++;
            $display("FAIL ignore_timing lat=%0d hold_bad=%0d required 10/0", lat, hold_bad);
        end
        extra = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bcd_s !== 16'h0042) extra++;
        end
        checks++;
        if (done_cnt - n0 !== 1 || extra !== 0) begin
            errors++;
            $display("FAIL ignore_single_done dones=%0d bad_bcd=%0d required 1/0", done_cnt - n0, extra);
        end
    endtask

    task automatic test_reset_abort();
        int lat, busy_n, hold_bad, n0;
        pulse_start(5678);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({bcd_s, busy_s, done_s, ovf_s} !== {16'h0000, 3'b000}) begin
            errors++;
            $display("FAIL abort_state bcd=%h busy=%b done=%b ovf=%b required 0000/0/0/0", bcd_s, busy_s, done_s, ovf_s);
        end
        sb.delete();
        n0 = done_cnt;
        repeat (20) @(negedge clk);
        checks++;
        if (done_cnt !== n0) begin
            errors++;
            $display("FAIL abort_no_done dones=%0d required 0", done_cnt - n0);
        end
        pulse_start(5678);
        wait_done(16'h0000, lat, busy_n, hold_bad);
        checks++;
        if (lat !== 15) begin
            errors++;
            $display("FAIL abort_restart_lat lat=%0d required 15", lat);
        end
    endtask

    task automatic test_back_to_back();
        int n0;
        @(negedge clk);
        @(negedge clk);
        done_cyc.delete();
        n0 = done_cnt;
        bin_in = 14'd2024;
        start  = 1'b1;
        for (int k = 0; k < 3; k++) push_exp(2024);
        repeat (40) @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        checks++;
        if (done_cnt - n0 !== 3 || done_cyc.size() !== 3) begin
            errors++;
            $display("FAIL b2b_count dones=%0d required 3", done_cnt - n0);
        end else begin
            checks++;
            if (done_cyc[1] - done_cyc[0] !== 16 || done_cyc[2] - done_cyc[1] !== 16) begin
                errors++;
                $display("FAIL b2b_spacing gaps=%0d,%0d required 16,16",
                         done_cyc[1] - done_cyc[0], done_cyc[2] - done_cyc[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_max();
        test_overflow();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain pending=%0d required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 The module SHALL have parameter SATURATE, default 1, which selects saturation when the input exceeds 9999 (1 = saturate, 0 = wrap).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge only.
REQ-003 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port start, input, 1 bit: conversion request, sampled only in IDLE.
REQ-005 The module SHALL have port bin_in, input, 14 bits: unsigned binary value (0..16383), sampled on the edge that accepts start.
REQ-006 The module SHALL have port bcd_out, output, 16 bits: four packed BCD digits, thousands in [15:12] and units in [3:0], which feed the 16-bit BCD input of the display driver directly.
REQ-007 The module SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-008 The module SHALL have port done, output, 1 bit: one-cycle pulse marking a conversion result.
REQ-009 The module SHALL have port overflow, output, 1 bit: high when the sampled bin_in exceeded 9999; valid with bcd_out.

Function
REQ-010 The module SHALL perform iterative double-dabble (shift-and-add-3) conversion, one bit per clock, MSB first, on a 20-bit (5-digit) BCD scratch register plus a 14-bit shift register.
REQ-011 The FSM SHALL have three states: IDLE, CONV, DONE.
REQ-012 In IDLE with start=1, the edge (E0) SHALL:
  - load bin_in into the shift register;
  - clear the scratch register;
  - clear the bit counter;
  - latch overflow_pending = (bin_in > 9999);
  - go to CONV.
REQ-013 In CONV, each edge SHALL add 3 to every scratch digit that is >= 5, then shift {scratch, shift-reg} left by one bit.
REQ-014 In CONV, the bit counter SHALL increment on each such edge.
REQ-015 The FSM SHALL leave CONV for DONE on the edge performing the 14th shift (E14).
REQ-016 On entry to DONE (edge E14), bcd_out SHALL be loaded from the scratch register:
  - SATURATE=1 and overflow_pending=1: 16'h9999;
  - otherwise: scratch[15:0], i.e. the ten-thousands digit is discarded.
REQ-017 On the same edge E14, overflow SHALL be loaded from overflow_pending.
REQ-018 DONE SHALL last exactly one cycle, during which done=1; DONE SHALL then return to IDLE.
REQ-019 Latency SHALL be fixed: done is high in the cycle following edge E14, independent of the data value.
REQ-020 busy SHALL be 1 in every cycle in CONV and 0 in IDLE and DONE.
REQ-021 done SHALL be 0 outside DONE.
REQ-022 bcd_out and overflow SHALL hold their last values between done pulses; intermediate scratch contents SHALL never appear on bcd_out.
REQ-023 A start asserted during CONV or DONE SHALL be ignored, not queued; bin_in changes during CONV SHALL have no effect.
REQ-024 A start held high continuously SHALL begin a new conversion on the first edge back in IDLE, giving back-to-back conversions every 16 cycles.
REQ-025 Values 0..9999 SHALL convert exactly; 0 SHALL yield 16'h0000.

Reset
REQ-026 When rst=1 at an edge, the FSM SHALL go to IDLE and the bit counter, scratch and shift registers SHALL clear.
REQ-027 When rst=1 at an edge, bcd_out SHALL become 16'h0000 and busy, done and overflow SHALL become 0.
REQ-028 rst SHALL take priority over start; an edge with rst=1 and start=1 SHALL remain in IDLE with no conversion accepted.
REQ-029 A reset during CONV or DONE SHALL abort the conversion with no done pulse; the next start after rst deasserts SHALL convert normally.

Verification
REQ-030 The bench SHALL check: bin_in=1234, start pulsed at E0 -> busy high for 14 cycles, done high for 1 cycle after E14, bcd_out=16'h1234, overflow=0.
REQ-031 The bench SHALL check: bin_in=0, then 9999 -> 16'h0000, then 16'h9999, overflow=0 both times; bcd_out holds 16'h0000 until the second done.
REQ-032 The bench SHALL check: SATURATE=1, bin_in=12345 -> bcd_out=16'h9999, overflow=1; SATURATE=0, bin_in=16383 -> bcd_out=16'h6383, overflow=1.
REQ-033 The bench SHALL check: start at E0 with bin_in=42, then start pulsed with bin_in=77 at E5 -> exactly one done, bcd_out=16'h0042.
REQ-034 The bench SHALL check: rst asserted at E7 of a conversion of 5678 -> no done pulse, bcd_out=16'h0000, busy=0; next start with 5678 -> 16'h5678 after 15 edges.
REQ-035 The bench SHALL check: start held high for 40 cycles with bin_in=2024 -> done pulses exactly 16 cycles apart, each with bcd_out=16'h2024.
